digi_ota_pdm_driver: RTL



---
 rtl/digi_ota_pdm_driver.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/digi_ota_pdm_driver.sv
`default_nettype none
// ============================================================================
//  Module   : digi_ota_pdm_driver
//  Purpose  : Differential pulse-density driver for the digital OTA Vip/Vin
//             pair. A valid/ready handshake fills a one-entry holding
//             register. A first-order sigma-delta accumulator then plays each
//             code as a complementary bitstream of LEN bits, one bit every DIV
//             clocks. Bursts chain without a gap while a code is waiting.
//  Options  : DIGI_OTA_PDM_DITHER_EN - when defined, the accumulator preload
//             comes from an 8-bit LFSR (x^8+x^6+x^5+x^4+1, seed 8'hA5) that
//             advances once per burst load. Otherwise the preload is the
//             constant 2^(WIDTH-1).
//  Revision : 1.0 - initial release
// ============================================================================
module digi_ota_pdm_driver #(
  parameter int WIDTH = 8,   // code width, 2..16
  parameter int DIV   = 4,   // clocks per PDM bit, >= 1
  parameter int LEN   = 256  // PDM bits per burst, >= 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [WIDTH-1:0] code_in,
  input  logic             code_valid,
  output logic             code_ready,
  output logic             vip,
  output logic             vin,
  output logic             busy
);

  localparam int c_dcw = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int c_bcw = $clog2(LEN + 1);
  localparam logic [c_dcw-1:0] c_div_last = c_dcw'(DIV - 1);
  localparam logic [c_bcw-1:0] c_len      = c_bcw'(LEN);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  hold_q, hold_d;
  logic              hold_full_q, hold_full_d;
  logic [WIDTH-1:0]  cur_q, cur_d;
  logic [WIDTH-1:0]  acc_q, acc_d;
  logic [c_dcw-1:0]  div_cnt_q, div_cnt_d;
  logic [c_bcw-1:0]  bit_cnt_q, bit_cnt_d;
  logic              vip_q, vip_d;
  logic              vin_q, vin_d;
  logic              busy_q, busy_d;

  logic              w_tick;
  logic              w_load;
  logic [WIDTH-1:0]  w_preload;
  logic [WIDTH:0]    w_sum_run;   // acc + cur, carry in the top bit
  logic [WIDTH:0]    w_sum_load;  // preload + held code for a chained reload

`ifdef DIGI_OTA_PDM_DITHER_EN
  logic [7:0] lfsr_q;
  logic       w_lfsr_fb;

  assign w_lfsr_fb = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];

  // Dither source: steps once per burst load so each burst gets a fresh preload
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= 8'hA5;
    end else if (w_load) begin
      lfsr_q <= {lfsr_q[6:0], w_lfsr_fb};
    end
  end

  generate
    if (WIDTH <= 8) begin : g_preload_trunc
      assign w_preload = lfsr_q[WIDTH-1:0];
    end else begin : g_preload_zext
      assign w_preload = {{(WIDTH-8){1'b0}}, lfsr_q};
    end
  endgenerate
`else
  assign w_preload = {1'b1, {(WIDTH-1){1'b0}}};
`endif

  assign w_tick     = (div_cnt_q == c_div_last);
  assign w_sum_run  = {1'b0, acc_q} + {1'b0, cur_q};
  assign w_sum_load = {1'b0, w_preload} + {1'b0, hold_q};

  assign code_ready = ~hold_full_q;
  assign vip        = vip_q;
  assign vin        = vin_q;
  assign busy       = busy_q;

  // Next-state logic: handshake, burst sequencing and sigma-delta step
  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    cur_d       = cur_q;
    acc_d       = acc_q;
    div_cnt_d   = div_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    vip_d       = vip_q;
    vin_d       = vin_q;
    w_load      = 1'b0;

    // Accept only into an empty holder, so it never collides with a load
    if (code_valid && !hold_full_q) begin
      hold_d      = code_in;
      hold_full_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        vip_d     = 1'b0;
        vin_d     = 1'b0;
        div_cnt_d = '0;
        if (enable && hold_full_q) begin
          state_d     = S_RUN;
          w_load      = 1'b1;
          cur_d       = hold_q;
          hold_full_d = 1'b0;
          acc_d       = w_preload;
          bit_cnt_d   = '0;
        end
      end
      S_RUN: begin
        if (!enable) begin
          // Abort: drop the current code, leave any held code in place
          state_d   = S_IDLE;
          vip_d     = 1'b0;
          vin_d     = 1'b0;
          div_cnt_d = '0;
          bit_cnt_d = '0;
        end else begin
          div_cnt_d = w_tick ? '0 : div_cnt_q + 1'b1;
          if (w_tick) begin
            if (bit_cnt_q < c_len) begin
              vip_d     = w_sum_run[WIDTH];
              vin_d     = ~w_sum_run[WIDTH];
              acc_d     = w_sum_run[WIDTH-1:0];
              bit_cnt_d = bit_cnt_q + 1'b1;
            end else if (hold_full_q) begin
              // Chain the next burst: its first bit replaces this tick's slot
              w_load      = 1'b1;
              cur_d       = hold_q;
              hold_full_d = 1'b0;
              vip_d       = w_sum_load[WIDTH];
              vin_d       = ~w_sum_load[WIDTH];
              acc_d       = w_sum_load[WIDTH-1:0];
              bit_cnt_d   = c_bcw'(1);
            end else begin
              state_d   = S_IDLE;
              vip_d     = 1'b0;
              vin_d     = 1'b0;
              bit_cnt_d = '0;
            end
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        vip_d   = 1'b0;
        vin_d   = 1'b0;
      end
    endcase

    busy_d = (state_d == S_RUN);
  end

  // State register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      cur_q       <= '0;
      acc_q       <= '0;
      div_cnt_q   <= '0;
      bit_cnt_q   <= '0;
      vip_q       <= 1'b0;
      vin_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      cur_q       <= cur_d;
      acc_q       <= acc_d;
      div_cnt_q   <= div_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      vip_q       <= vip_d;
      vin_q       <= vin_d;
      busy_q      <= busy_d;
    end
  end

endmodule
`default_nettype wire
